// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary systolic MAC engine.
package sa_pkg;

   localparam int SA_DATA_W = 8;
   localparam int SA_ACC_W  = 32;
   localparam int SA_ROWS   = 4;
   localparam int SA_COLS   = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_DRAIN   = 2'd3
   } sa_state_e;

endpackage

// File: rtl/sa_if.sv
// Stream bundle of the engine: weight rows in, activation vectors in, result vectors out.
interface sa_if
   import sa_pkg::*;
#(
   parameter int DATA_W = SA_DATA_W,
   parameter int ACC_W  = SA_ACC_W,
   parameter int ROWS   = SA_ROWS,
   parameter int COLS   = SA_COLS
) ();

   logic                    i_w_vld;
   logic                    o_w_rdy;
   logic [COLS*DATA_W-1:0]  i_w_row;

   logic                    i_a_vld;
   logic                    o_a_rdy;
   logic [ROWS*DATA_W-1:0]  i_a_vec;
   logic                    i_a_last;

   logic                    o_c_vld;
   logic                    i_c_rdy;
   logic [COLS*ACC_W-1:0]   o_c_vec;
   logic                    o_c_last;

   modport master (
      output i_w_vld, i_w_row, i_a_vld, i_a_vec, i_a_last, i_c_rdy,
      input  o_w_rdy, o_a_rdy, o_c_vld, o_c_vec, o_c_last
   );

   modport slave (
      input  i_w_vld, i_w_row, i_a_vld, i_a_vec, i_a_last, i_c_rdy,
      output o_w_rdy, o_a_rdy, o_c_vld, o_c_vec, o_c_last
   );

endinterface

// File: rtl/sa_pe.sv
// Weight-stationary MAC cell: holds one weight, passes the activation right
// and the partial sum down, with the vector tag riding alongside the activation.
module sa_pe
   import sa_pkg::*;
#(
   parameter int DATA_W = SA_DATA_W,
   parameter int ACC_W  = SA_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic                     i_w_we,
   input  logic signed [DATA_W-1:0] i_w,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic                     i_vld,
   input  logic                     i_last,
   input  logic signed [ACC_W-1:0]  i_psum,
   output logic signed [DATA_W-1:0] o_a,
   output logic                     o_vld,
   output logic                     o_last,
   output logic signed [ACC_W-1:0]  o_psum
);

   logic signed [DATA_W-1:0]   r_w;
   logic signed [DATA_W-1:0]   r_a;
   logic                       r_vld;
   logic                       r_last;
   logic signed [ACC_W-1:0]    r_psum;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_sum;

   assign w_prod = i_a * r_w;
   assign w_sum  = i_psum + ACC_W'(w_prod);

   // Stationary weight, written only while the array is being loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_w <= '0;
      end else if (i_w_we) begin
         r_w <= i_w;
      end
   end

   // Pipeline stage of the cell; frozen while the output is back-pressured.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a    <= '0;
         r_vld  <= 1'b0;
         r_last <= 1'b0;
         r_psum <= '0;
      end else if (i_en) begin
         r_a    <= i_a;
         r_vld  <= i_vld;
         r_last <= i_last;
         r_psum <= w_sum;
      end
   end

   assign o_a    = r_a;
   assign o_vld  = r_vld;
   assign o_last = r_last;
   assign o_psum = r_psum;

endmodule

// File: rtl/sa_engine.sv
// Weight-stationary systolic matrix-vector engine: C[j] = sum_r A[r]*W[r][j].
// Activations enter skewed by lane, sums leave deskewed by column, so every
// result appears ROWS+COLS unstalled cycles after its vector was accepted.
//
//   state   | meaning
//   IDLE    | waiting; accepts a weight row (starts LOAD) or, once loaded, a vector
//   LOAD    | accepting weight rows 1..ROWS-1 into PE rows
//   COMPUTE | streaming activation vectors until one marked last
//   DRAIN   | no new input; waits for the last result to leave
module sa_engine
   import sa_pkg::*;
#(
   parameter int DATA_W = SA_DATA_W,
   parameter int ACC_W  = SA_ACC_W,
   parameter int ROWS   = SA_ROWS,
   parameter int COLS   = SA_COLS
) (
   input  logic clk,
   input  logic rst,
   sa_if.slave  bus,
   output logic o_busy
);

   localparam int              ROW_W    = $clog2(ROWS);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   sa_state_e              r_state;
   sa_state_e              w_state_nxt;
   logic [ROW_W-1:0]       r_row;
   logic                   r_w_loaded;
   logic                   w_w_rdy;
   logic                   w_a_rdy;
   logic                   w_busy;
   logic                   w_w_acc;
   logic                   w_a_acc;
   logic                   w_stall;
   logic                   w_en;

   logic                   r_c_vld;
   logic                   r_c_last;
   logic [COLS*ACC_W-1:0]  r_c_vec;

   logic [1:0]               r_tag_sk [ROWS];
   logic signed [DATA_W-1:0] w_a_h    [ROWS][COLS+1];
   logic                     w_vld_h  [ROWS][COLS+1];
   logic                     w_last_h [ROWS][COLS+1];
   logic signed [ACC_W-1:0]  w_ps_v   [ROWS+1][COLS];
   logic signed [ACC_W-1:0]  w_col    [COLS];
   logic signed [DATA_W-1:0] w_w_val  [COLS];

   assign w_stall = r_c_vld & ~bus.i_c_rdy;
   assign w_en    = ~w_stall;
   assign w_w_acc = bus.i_w_vld & w_w_rdy;
   assign w_a_acc = bus.i_a_vld & w_a_rdy;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake readies. In IDLE a pending weight beat takes
   // priority so an activation never enters while row 0 is being rewritten.
   always_comb begin
      w_state_nxt = r_state;
      w_w_rdy     = 1'b0;
      w_a_rdy     = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy  = 1'b0;
            w_w_rdy = 1'b1;
            w_a_rdy = r_w_loaded & ~bus.i_w_vld;
            if (w_w_acc) begin
               w_state_nxt = ST_LOAD;
            end else if (w_a_acc) begin
               w_state_nxt = bus.i_a_last ? ST_DRAIN : ST_COMPUTE;
            end
         end
         ST_LOAD: begin
            w_w_rdy = 1'b1;
            if (w_w_acc && (r_row == ROW_LAST)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_COMPUTE: begin
            w_a_rdy = ~w_stall;
            if (w_a_acc && bus.i_a_last) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (r_c_vld && r_c_last && bus.i_c_rdy) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Weight row counter; a load only counts as complete on its final row.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row      <= '0;
         r_w_loaded <= 1'b0;
      end else if (w_w_acc) begin
         if (r_row == ROW_LAST) begin
            r_row      <= '0;
            r_w_loaded <= 1'b1;
         end else begin
            r_row      <= r_row + 1'b1;
            r_w_loaded <= 1'b0;
         end
      end
   end

   // Tag skew line: tap r carries {last, vld} delayed to match lane r.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROWS; i++) r_tag_sk[i] <= '0;
      end else if (w_en) begin
         r_tag_sk[0] <= {w_a_acc & bus.i_a_last, w_a_acc};
         for (int i = 1; i < ROWS; i++) r_tag_sk[i] <= r_tag_sk[i-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_wval
      assign w_w_val[c] = bus.i_w_row[c*DATA_W +: DATA_W];
      assign w_ps_v[0][c] = '0;
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic signed [DATA_W-1:0] r_sk [0:r];

      // Input skew: lane r sees its activation r cycles after lane 0.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i <= r; i++) r_sk[i] <= '0;
         end else if (w_en) begin
            r_sk[0] <= bus.i_a_vec[r*DATA_W +: DATA_W];
            for (int i = 1; i <= r; i++) r_sk[i] <= r_sk[i-1];
         end
      end

      assign w_a_h[r][0]    = r_sk[r];
      assign w_vld_h[r][0]  = r_tag_sk[r][0];
      assign w_last_h[r][0] = r_tag_sk[r][1];
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam logic [ROW_W-1:0] RIDX = ROW_W'(r);
      for (genvar c = 0; c < COLS; c++) begin : g_col
         sa_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_en),
            .i_w_we (w_w_acc && (r_row == RIDX)),
            .i_w    (w_w_val[c]),
            .i_a    (w_a_h[r][c]),
            .i_vld  (w_vld_h[r][c]),
            .i_last (w_last_h[r][c]),
            .i_psum (w_ps_v[r][c]),
            .o_a    (w_a_h[r][c+1]),
            .o_vld  (w_vld_h[r][c+1]),
            .o_last (w_last_h[r][c+1]),
            .o_psum (w_ps_v[r+1][c])
         );
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_dsk
      localparam int DLY = COLS - 1 - c;
      if (DLY == 0) begin : g_pass
         assign w_col[c] = w_ps_v[ROWS][c];
      end else begin : g_dly
         logic signed [ACC_W-1:0] r_dsk [DLY];

         // Output deskew: column c waits until the last column catches up.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DLY; i++) r_dsk[i] <= '0;
            end else if (w_en) begin
               r_dsk[0] <= w_ps_v[ROWS][c];
               for (int i = 1; i < DLY; i++) r_dsk[i] <= r_dsk[i-1];
            end
         end

         assign w_col[c] = r_dsk[DLY-1];
      end
   end

   // Result register; the bottom-right cell's tag marks a real vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c_vld  <= 1'b0;
         r_c_last <= 1'b0;
         r_c_vec  <= '0;
      end else if (w_en) begin
         r_c_vld  <= w_vld_h[ROWS-1][COLS];
         r_c_last <= w_last_h[ROWS-1][COLS];
         for (int c = 0; c < COLS; c++) r_c_vec[c*ACC_W +: ACC_W] <= w_col[c];
      end
   end

   assign bus.o_w_rdy  = w_w_rdy;
   assign bus.o_a_rdy  = w_a_rdy;
   assign bus.o_c_vld  = r_c_vld;
   assign bus.o_c_last = r_c_last;
   assign bus.o_c_vec  = r_c_vec;
   assign o_busy       = w_busy;

endmodule

// File: tb/tb_sa_engine.sv
// Bench for sa_engine: directed scenarios plus random streams, checked against
// a plain matrix-vector reference with an expected-result queue.
module tb_sa_engine;
   import sa_pkg::*;

   localparam int DW = 8;
   localparam int AW = 32;
   localparam int R  = 4;
   localparam int C  = 4;

   logic clk = 1'b0;
   logic rst;
   logic o_busy;

   always #5 clk = ~clk;

   sa_if #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C)) bus ();

   sa_engine #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .o_busy (o_busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model state
   int tb_w [R][C];
   int ld_w [R][C];

   typedef struct {
      logic [C*AW-1:0] vec;
      logic            last;
      int              nst;
   } exp_t;

   exp_t            q[$];
   exp_t            e;
   int              nst = 0;
   bit              prev_held = 1'b0;
   logic [C*AW-1:0] held_vec;
   logic            held_last;
   logic [C*AW-1:0] last_res;
   int              n_res = 0;
   int              last_wait;

   function automatic logic [C*AW-1:0] ref_c(input logic [R*DW-1:0] a);
      logic [C*AW-1:0] res;
      longint          s;
      res = '0;
      for (int j = 0; j < C; j++) begin
         s = 0;
         for (int r = 0; r < R; r++) s += longint'($signed(a[r*DW +: DW])) * longint'(tb_w[r][j]);
         res[j*AW +: AW] = s[AW-1:0];
      end
      return res;
   endfunction

   // result monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         prev_held = 1'b0;
      end else begin
         if (prev_held) begin
            chk("hold_vld", bus.o_c_vld, 1);
            chk("hold_vec", bus.o_c_vec, held_vec);
            chk("hold_last", bus.o_c_last, held_last);
         end else if (q.size() == 0) begin
            chk("spurious_vld", bus.o_c_vld, 0);
         end else if (bus.o_c_vld) begin
            e = q.pop_front();
            chk("latency", nst - e.nst, R + C);
            chk("c_vec", bus.o_c_vec, e.vec);
            chk("c_last", bus.o_c_last, e.last);
            last_res = bus.o_c_vec;
            n_res++;
         end
         prev_held = bus.o_c_vld & ~bus.i_c_rdy;
         held_vec  = bus.o_c_vec;
         held_last = bus.o_c_last;
         if (!prev_held) nst++;
         if (bus.i_a_vld && bus.o_a_rdy) q.push_back('{ref_c(bus.i_a_vec), bus.i_a_last, nst});
      end
   end

   // result-side ready generator
   int cyc = 0;
   int stall_until = 0;
   bit rdy_rand = 1'b0;
   always @(posedge clk) begin
      #2;
      cyc++;
      if (cyc < stall_until) bus.i_c_rdy = 1'b0;
      else if (rdy_rand)     bus.i_c_rdy = 1'($urandom_range(0, 1));
      else                   bus.i_c_rdy = 1'b1;
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) sync();
   endtask

   function automatic logic [R*DW-1:0] rand_vec();
      logic [R*DW-1:0] v;
      for (int r = 0; r < R; r++) v[r*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   task automatic rand_w();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) ld_w[r][c] = int'($urandom_range(0, 255)) - 128;
   endtask

   task automatic send(input logic [R*DW-1:0] a, input logic last);
      bit acc = 1'b0;
      bus.i_a_vld  = 1'b1;
      bus.i_a_vec  = a;
      bus.i_a_last = last;
      last_wait    = 0;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = bus.o_a_rdy;
         last_wait++;
         sync();
      end
      chk("a_accept", acc, 1);
      bus.i_a_vld = 1'b0;
   endtask

   task automatic load(input int nb);
      bit acc;
      for (int k = 0; k < nb; k++) begin
         acc = 1'b0;
         bus.i_w_vld = 1'b1;
         for (int c = 0; c < C; c++) bus.i_w_row[c*DW +: DW] = DW'(ld_w[k][c]);
         for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.o_w_rdy;
            sync();
         end
         chk("w_accept", acc, 1);
      end
      bus.i_w_vld = 1'b0;
      if (nb == R) tb_w = ld_w;
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 300 && !idle; i++) begin
         @(negedge clk);
         idle = !o_busy;
         sync();
      end
      chk("to_idle", idle, 1);
   endtask

   task automatic chk_quiet(input string tag);
      @(negedge clk);
      chk({tag, "_c_vld"}, bus.o_c_vld, 0);
      chk({tag, "_c_last"}, bus.o_c_last, 0);
      chk({tag, "_c_vec"}, bus.o_c_vec, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_w_rdy"}, bus.o_w_rdy, 1);
      chk({tag, "_a_rdy"}, bus.o_a_rdy, 0);
      sync();
   endtask

   logic [R*DW-1:0] a;
   logic [C*AW-1:0] want;
   int              n0;

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      bus.i_w_vld  = 1'b0;
      bus.i_w_row  = '0;
      bus.i_a_vld  = 1'b0;
      bus.i_a_vec  = '0;
      bus.i_a_last = 1'b0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) tb_w[r][c] = 0;
      step(3);
      chk_quiet("rst");
      rst = 1'b0;
      chk_quiet("post_rst");

      // activation without weights is refused; partial load keeps it refused
      bus.i_a_vld = 1'b1;
      bus.i_a_vec = rand_vec();
      repeat (5) begin
         @(negedge clk);
         chk("a_rdy_noload", bus.o_a_rdy, 0);
         sync();
      end
      bus.i_a_vld = 1'b0;
      step(12);
      rand_w();
      load(2);
      step(4);
      bus.i_a_vld = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("a_rdy_partial", bus.o_a_rdy, 0);
         sync();
      end
      bus.i_a_vld = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;

      // identity weights
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) ld_w[r][c] = (r == c) ? 1 : 0;
      load(R);
      for (int r = 0; r < R; r++) a[r*DW +: DW] = DW'(r + 1);
      n0 = n_res;
      send(a, 1'b1);
      wait_idle();
      for (int c = 0; c < C; c++) want[c*AW +: AW] = AW'(c + 1);
      chk("ident_res", last_res, want);
      chk("ident_count", n_res - n0, 1);

      // extreme operands, back to back
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) ld_w[r][c] = -128;
      load(R);
      for (int r = 0; r < R; r++) a[r*DW +: DW] = 8'h80;
      n0 = n_res;
      for (int i = 0; i < 8; i++) begin
         send(a, i == 7);
         chk("b2b_wait", last_wait, 1);
      end
      wait_idle();
      for (int c = 0; c < C; c++) want[c*AW +: AW] = 32'd65536;
      chk("b2b_res", last_res, want);
      chk("b2b_count", n_res - n0, 8);

      // weight beats during compute are refused
      rand_w();
      load(R);
      n0 = n_res;
      for (int i = 0; i < 4; i++) begin
         send(rand_vec(), i == 3);
         if (i == 0) begin
            bus.i_w_vld = 1'b1;
            bus.i_w_row = '1;
         end
         chk("w_rdy_busy", bus.o_w_rdy, 0);
      end
      bus.i_w_vld = 1'b0;
      wait_idle();
      chk("wblock_count", n_res - n0, 4);

      // streams with back-pressure: one fixed 3-cycle stall, then random
      rand_w();
      load(R);
      for (int b = 0; b < 4; b++) begin
         rdy_rand = (b > 0);
         n0 = n_res;
         for (int i = 0; i < 6; i++) begin
            send(rand_vec(), i == 5);
            if (b == 0 && i == 2) stall_until = cyc + 4;
            if (b > 0 && $urandom_range(0, 3) == 0) step(1);
         end
         wait_idle();
         chk("stream_count", n_res - n0, 6);
      end
      rdy_rand = 1'b0;
      step(2);

      // reset in the middle of a burst discards everything
      rand_w();
      load(R);
      send(rand_vec(), 1'b0);
      send(rand_vec(), 1'b0);
      rst = 1'b1;
      step(2);
      chk_quiet("midrst");
      rst = 1'b0;
      step(20);
      chk_quiet("after_midrst");

      chk("q_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
